// File: rtl/reservation_alu2_scheduler.sv
// reservation_alu2_scheduler: ALU2 reservation-station allocation and oldest-ready issue control.
// Optional perf counters are enabled with RESERVATION_ALU2_PERF_CNT_EN.
module reservation_alu2_scheduler #(
  parameter int ENTRY_N = 4,
  parameter int ENTRY_AW = 2
)(
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iREMOVE_VALID,
  input  logic                iREGIST_VALID,
  output logic                oREGIST_LOCK,
  output logic [ENTRY_N-1:0]  oREGIST_ENTRY_VALID,
  input  logic [ENTRY_N-1:0]  iENTRY_VALID,
  input  logic [ENTRY_N-1:0]  iENTRY_REGIST_LOCK,
  input  logic [ENTRY_N-1:0]  iENTRY_MATCHING,
  input  logic                iEXEC_LOCK,
  output logic [ENTRY_N-1:0]  oEXOUT_VALID,
  output logic                oISSUE_VALID,
  output logic [ENTRY_AW-1:0] oISSUE_SEL,
  output logic [ENTRY_AW:0]   oINFO_COUNT
`ifdef RESERVATION_ALU2_PERF_CNT_EN
  ,
  output logic [31:0]         oPERF_ISSUE_CNT,
  output logic [31:0]         oPERF_FULL_CNT
`endif
);
  localparam logic [ENTRY_N-1:0] ONE = ENTRY_N'(1);
  logic [ENTRY_N-1:0] free, target, ready, cand, grant;
  logic [ENTRY_N-1:0] older [ENTRY_N];
  logic [ENTRY_AW:0] count;
  logic [ENTRY_AW-1:0] sel;
  logic regist, issue;
  assign free = ~iENTRY_VALID & ~iENTRY_REGIST_LOCK;
  // x & -x isolates the lowest set bit
  assign target = free & (~free + ONE);
  assign oREGIST_LOCK = (count == (ENTRY_AW+1)'(ENTRY_N)) || !(|free) || iREMOVE_VALID;
  assign regist = iREGIST_VALID && !oREGIST_LOCK;
  assign oREGIST_ENTRY_VALID = regist ? target : '0;
  assign ready = iENTRY_VALID & iENTRY_MATCHING;
  // an entry is a candidate when no other ready entry is older than it
  always_comb begin
    for (int i = 0; i < ENTRY_N; i++) begin
      cand[i] = ready[i];
      for (int j = 0; j < ENTRY_N; j++)
        if (j != i && ready[j] && older[j][i]) cand[i] = 1'b0;
    end
  end
  // equal-age ties (after reset/flush) resolve to the lowest index
  assign grant = cand & (~cand + ONE);
  always_comb begin
    sel = '0;
    for (int i = 0; i < ENTRY_N; i++)
      if (grant[i]) sel = ENTRY_AW'(i);
  end
  assign issue = (|grant) && !iEXEC_LOCK && !iREMOVE_VALID;
  assign oISSUE_VALID = issue;
  assign oEXOUT_VALID = issue ? grant : '0;
  assign oISSUE_SEL = sel;
  assign oINFO_COUNT = count;
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      for (int i = 0; i < ENTRY_N; i++) older[i] <= '0;
      count <= '0;
    end else if (iREMOVE_VALID) begin
      for (int i = 0; i < ENTRY_N; i++) older[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < ENTRY_N; i++)
        for (int j = 0; j < ENTRY_N; j++)
          if (i == j) older[i][j] <= 1'b0;
          else if (issue && (grant[i] || grant[j])) older[i][j] <= 1'b0;
          else if (regist && target[i]) older[i][j] <= 1'b0;
          else if (regist && target[j]) older[i][j] <= 1'b1;
      count <= count + (ENTRY_AW+1)'(regist) - (ENTRY_AW+1)'(issue);
    end
  end
`ifdef RESERVATION_ALU2_PERF_CNT_EN
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oPERF_ISSUE_CNT <= '0;
      oPERF_FULL_CNT <= '0;
    end else begin
      oPERF_ISSUE_CNT <= oPERF_ISSUE_CNT + 32'(issue);
      oPERF_FULL_CNT <= oPERF_FULL_CNT + 32'(iREGIST_VALID && oREGIST_LOCK && !iREMOVE_VALID);
    end
  end
`endif
endmodule
